// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, FSM state type and constants for the sequential divider.
package div_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam logic [DATA_W-1:0] DIV0_QUOT = 16'hFFFF;

`ifdef SEQ_DIV_SIGNED_EN
    // Two's-complement magnitude; -32768 maps to 16'h8000, which the unsigned core handles.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction
`endif

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration.
module div_step
    import div_pkg::*;
(
    input  logic [DATA_W:0]   rem_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic              q_bit
);

    logic [DATA_W:0] diff;

    // rem_in <= 2*divisor-1, so the 17-bit difference always carries the true sign.
    assign diff    = rem_in - {1'b0, divisor};
    assign q_bit   = ~diff[DATA_W];
    assign rem_out = q_bit ? diff[DATA_W-1:0] : rem_in[DATA_W-1:0];

endmodule

// File: rtl/seq_divider_16bit.sv
// rtl/seq_divider_16bit.sv - 16-bit restoring divider, one quotient bit per cycle.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider_16bit
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] dvd_q, dvd_d;
    logic [DATA_W-1:0] dsr_q, dsr_d;
    logic [DATA_W-1:0] quotient_q, quotient_d;
    logic [DATA_W-1:0] remainder_q, remainder_d;
    logic              dbz_q, dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
`endif

    logic [DATA_W:0]   step_in;
    logic [DATA_W-1:0] step_rem;
    logic              step_q;
    logic [DATA_W-1:0] final_quot;

    // Dividend register shifts out its MSB and collects quotient bits from the right.
    assign step_in    = {rem_q, dvd_q[DATA_W-1]};
    assign final_quot = {dvd_q[DATA_W-2:0], step_q};

    div_step u_step (
        .rem_in  (step_in),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quotient_d  = DIV0_QUOT;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = DONE;
                    end else begin
                        rem_d   = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = CALC;
`ifdef SEQ_DIV_SIGNED_EN
                        dvd_d  = mag(dividend);
                        dsr_d  = mag(divisor);
                        qneg_d = dividend[DATA_W-1] ^ divisor[DATA_W-1];
                        rneg_d = dividend[DATA_W-1];
`else
                        dvd_d  = dividend;
                        dsr_d  = divisor;
`endif
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = final_quot;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DONE;
`ifdef SEQ_DIV_SIGNED_EN
                    quotient_d  = qneg_q ? (~final_quot + 1'b1) : final_quot;
                    remainder_d = rneg_q ? (~step_rem + 1'b1) : step_rem;
`else
                    quotient_d  = final_quot;
                    remainder_d = step_rem;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
`endif
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
